// File: rtl/piso_pkg.sv
// Shared types and helpers for the parametrised PISO serializer.
package piso_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   // Counter width for a count of n values, never narrower than one bit.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/piso_serializer_bit_tick_gen.sv
// Bit-period divider: tick is high on the last clock of each DIV-cycle bit slot.
module bit_tick_gen
   import piso_pkg::*;
#(
   parameter int DIV = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);

   localparam int CW = clog2_min1(DIV);
   localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

   logic [CW-1:0] div_cnt_q, div_cnt_d;

   // Free-running between frames; restart aligns the slot to a new frame.
   always_comb begin
      div_cnt_d = div_cnt_q;
      if (restart || (div_cnt_q == '0)) begin
         div_cnt_d = RELOAD;
      end else begin
         div_cnt_d = div_cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         div_cnt_q <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
      end
   end

   assign tick = (div_cnt_q == '0);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter with valid/ready load, programmable bit
// period, selectable direction and back-to-back frame streaming.
module piso_serializer
   import piso_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int DIV       = 1,
   parameter bit LSB_FIRST = 1'b0,
   parameter bit IDLE_LVL  = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] pi,
   output logic             so,
   output logic             so_valid,
   output logic             busy,
   output logic             done
);

   localparam int BW = clog2_min1(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic             so_q, so_d;
   logic             so_valid_q, so_valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             tick, last_bit, accept;

   bit_tick_gen #(.DIV(DIV)) u_tick (
      .clk     (clk),
      .rst     (rst),
      .restart (accept),
      .tick    (tick)
   );

   // The final bit slot doubles as a load window so frames stream with no gap.
   assign last_bit   = (state_q == SHIFT) && (bit_cnt_q == '0) && tick;
   assign load_ready = (state_q == IDLE) || last_bit;
   assign accept     = load_valid && load_ready;

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      if (accept) begin
         state_d   = SHIFT;
         shreg_d   = pi;
         bit_cnt_d = BW'(WIDTH - 1);
      end else if ((state_q == SHIFT) && tick) begin
         if (bit_cnt_q == '0) begin
            state_d = IDLE;
            shreg_d = '0;
         end else begin
            shreg_d   = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
            bit_cnt_d = bit_cnt_q - BW'(1);
         end
      end
   end

   // Outputs are computed from next state so so/so_valid line up with the register.
   always_comb begin
      so_d       = IDLE_LVL;
      so_valid_d = (state_d == SHIFT);
      busy_d     = (state_d == SHIFT);
      done_d     = last_bit;
      if (state_d == SHIFT) begin
         so_d = LSB_FIRST ? shreg_d[0] : shreg_d[WIDTH-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         shreg_q    <= '0;
         bit_cnt_q  <= '0;
         so_q       <= IDLE_LVL;
         so_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         bit_cnt_q  <= bit_cnt_d;
         so_q       <= so_d;
         so_valid_q <= so_valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign so       = so_q;
   assign so_valid = so_valid_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: three configurations share clk/rst.
module tb_piso_serializer;

   typedef struct packed {
      logic data;
      logic last;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] lv;
   logic [3:0] pi_a, pi_b;
   logic [7:0] pi_c;
   logic [2:0] lr_w, so_w, sv_w, busy_w, done_w;

   exp_t q[3][$];
   logic prev_last[3];
   logic mon_en = 1'b0;
   int   n_cmp  = 0;
   int   n_bad  = 0;
   localparam logic [2:0] IL = 3'b010;

   always #5 clk = ~clk;

   // A: W4 DIV1 MSB first; B: W4 DIV3 LSB first idle-high; C: W8 DIV2 MSB first.
   piso_serializer #(.WIDTH(4), .DIV(1), .LSB_FIRST(1'b0), .IDLE_LVL(1'b0)) u_a (
      .clk(clk), .rst(rst), .load_valid(lv[0]), .load_ready(lr_w[0]), .pi(pi_a),
      .so(so_w[0]), .so_valid(sv_w[0]), .busy(busy_w[0]), .done(done_w[0]));
   piso_serializer #(.WIDTH(4), .DIV(3), .LSB_FIRST(1'b1), .IDLE_LVL(1'b1)) u_b (
      .clk(clk), .rst(rst), .load_valid(lv[1]), .load_ready(lr_w[1]), .pi(pi_b),
      .so(so_w[1]), .so_valid(sv_w[1]), .busy(busy_w[1]), .done(done_w[1]));
   piso_serializer #(.WIDTH(8), .DIV(2), .LSB_FIRST(1'b0), .IDLE_LVL(1'b0)) u_c (
      .clk(clk), .rst(rst), .load_valid(lv[2]), .load_ready(lr_w[2]), .pi(pi_c),
      .so(so_w[2]), .so_valid(sv_w[2]), .busy(busy_w[2]), .done(done_w[2]));

   task automatic chk(input string tag, input int inst, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s inst=%0d observed=%0h expected=%0h", tag, inst, obs, exp);
      end
   endtask

   // Expected serial stream: one entry per clock the bit is held.
   task automatic push(input int i, input logic [7:0] w, input int width,
                       input int div, input bit lsb);
      logic bv;
      for (int b = 0; b < width; b++) begin
         bv = lsb ? w[b] : w[width-1-b];
         for (int d = 0; d < div; d++)
            q[i].push_back('{data: bv, last: (b == width-1) && (d == div-1)});
      end
   endtask

   task automatic monitor();
      exp_t e;
      if (!mon_en) return;
      for (int i = 0; i < 3; i++) begin
         chk("done", i, 32'(done_w[i]), 32'(prev_last[i]));
         chk("busy_eq_valid", i, 32'(busy_w[i]), 32'(sv_w[i]));
         prev_last[i] = 1'b0;
         if (sv_w[i]) begin
            n_cmp++;
            assert (q[i].size() != 0) else begin
               n_bad++;
               $error("FAIL unexpected_so_valid inst=%0d observed=1 expected=0", i);
            end
            if (q[i].size() != 0) begin
               e = q[i].pop_front();
               chk("so", i, 32'(so_w[i]), 32'(e.data));
               prev_last[i] = e.last;
            end
         end else begin
            chk("so_idle", i, 32'(so_w[i]), 32'(IL[i]));
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 3; i++) prev_last[i] = 1'b0;
      rst = 1'b0; lv = '0; pi_a = '0; pi_b = '0; pi_c = '0;
      @(posedge clk); #1;
      mon_en = 1'b1;
      step();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("reset_load_ready", i, 32'(lr_w[i]), 32'd1);
         chk("reset_so_valid", i, 32'(sv_w[i]), 32'd0);
      end

      // MSB-first single frame
      lv[0] = 1'b1; pi_a = 4'b1010; push(0, 8'(pi_a), 4, 1, 1'b0);
      step();
      lv[0] = 1'b0;
      chk("busy_load_ready", 0, 32'(lr_w[0]), 32'd0);
      repeat (6) step();

      // LSB-first, 3 clocks per bit, idle level high
      lv[1] = 1'b1; pi_b = 4'b1101; push(1, 8'(pi_b), 4, 3, 1'b1);
      step();
      lv[1] = 1'b0;
      repeat (14) step();

      // back-to-back frames with load_valid held
      lv[0] = 1'b1; pi_a = 4'b1001; push(0, 8'(pi_a), 4, 1, 1'b0);
      step();
      pi_a = 4'b0110; push(0, 8'(pi_a), 4, 1, 1'b0);
      repeat (3) step();
      chk("last_bit_load_ready", 0, 32'(lr_w[0]), 32'd1);
      step();
      lv[0] = 1'b0;
      repeat (6) step();

      // load attempts mid-frame are ignored
      lv[0] = 1'b1; pi_a = 4'b1111; push(0, 8'(pi_a), 4, 1, 1'b0);
      step();
      pi_a = 4'b0000;
      chk("midframe_load_ready", 0, 32'(lr_w[0]), 32'd0);
      repeat (2) step();
      lv[0] = 1'b0;
      repeat (6) step();

      // reset wins over a simultaneous load
      rst = 1'b0; lv[0] = 1'b1; pi_a = 4'b1111;
      step();
      rst = 1'b1; lv[0] = 1'b0;
      chk("rst_prio_busy", 0, 32'(busy_w[0]), 32'd0);
      chk("rst_prio_load_ready", 0, 32'(lr_w[0]), 32'd1);
      repeat (3) step();

      // reset during bit 2 of an 8-bit frame, then a clean restart
      lv[2] = 1'b1; pi_c = 8'hB4; push(2, pi_c, 8, 2, 1'b0);
      step();
      lv[2] = 1'b0;
      repeat (4) step();
      rst = 1'b0;
      step();
      q[2].delete();
      rst = 1'b1;
      chk("abort_so_valid", 2, 32'(sv_w[2]), 32'd0);
      chk("abort_busy", 2, 32'(busy_w[2]), 32'd0);
      chk("abort_done", 2, 32'(done_w[2]), 32'd0);
      chk("abort_so", 2, 32'(so_w[2]), 32'd0);
      lv[2] = 1'b1; pi_c = 8'h3C; push(2, pi_c, 8, 2, 1'b0);
      step();
      lv[2] = 1'b0;
      repeat (20) step();

      for (int i = 0; i < 3; i++)
         chk("queue_drained", i, 32'(q[i].size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
